sobel_stream_filter: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge filter for raster-order pixel streams (one pixel per in_flag).

---
 rtl/sobel_stream_filter_pkg.sv | 18 +
 rtl/sobel_stream_filter_line_buffer.sv | 30 +++
 rtl/sobel_stream_filter.sv | 170 +++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_stream_filter_pkg.sv
// Shared constants for the Sobel stream filter: output modes, fill values,
// reset threshold and gradient width helper.
package sobel_stream_filter_pkg;

   localparam int unsigned ModeBinary = 0;
   localparam int unsigned ModeMag    = 1;

   // Binary-mode fill bits: edges are drawn black on a white background.
   localparam logic EdgeBlack = 1'b0;
   localparam logic EdgeWhite = 1'b1;

   localparam int unsigned ThrReset = 12;

   function automatic int unsigned grad_w(input int unsigned pix_w);
      return pix_w + 3;
   endfunction

endpackage

// File: rtl/sobel_stream_filter_line_buffer.sv
// Two-row line buffer addressed by column; combinational read, row 0 cascades into row 1
// on each write so the read values are always the two rows above the incoming pixel.
module sobel_stream_filter_line_buffer #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 180,
   parameter int unsigned AW    = $clog2(IMG_W)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [PIX_W-1:0] wdata_i,
   output logic [PIX_W-1:0] line0_o,
   output logic [PIX_W-1:0] line1_o
);

   logic [PIX_W-1:0] line0_q [IMG_W];
   logic [PIX_W-1:0] line1_q [IMG_W];

   assign line0_o = line0_q[addr_i];
   assign line1_o = line1_q[addr_i];

   // Contents are never read before being rewritten, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         line0_q[addr_i] <= wdata_i;
         line1_q[addr_i] <= line0_q[addr_i];
      end
   end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: raster counters, 3x3 window, 3-stage pipeline
// (window load, Gx/Gy, magnitude/threshold) with frame and line markers.
module sobel_stream_filter
   import sobel_stream_filter_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 180,
   parameter int unsigned IMG_H = 180,
   parameter int unsigned MODE  = 0
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [PIX_W-1:0] data_in,
   input  logic             in_flag,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] threshold,
   output logic [PIX_W-1:0] data_out,
   output logic             out_flag,
   output logic             out_sof,
   output logic             out_eol,
   output logic             frame_done
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned GW = grad_w(PIX_W);
   localparam int unsigned MW = GW + 1;

   localparam logic [CW-1:0]    ColLast = CW'(IMG_W - 1);
   localparam logic [RW-1:0]    RowLast = RW'(IMG_H - 1);
   localparam logic [PIX_W-1:0] PixMax  = '1;

   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic [PIX_W-1:0] thr_q;
   logic [PIX_W-1:0] lb_line0, lb_line1;
   logic [PIX_W-1:0] win_q [3][3];
   logic win_ok, first_pix;

   logic             v0_q, sof0_q, eol0_q, done0_q;
   logic [PIX_W-1:0] thr0_q;
   logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
   logic             v1_q, sof1_q, eol1_q, done1_q;
   logic [PIX_W-1:0] thr1_q;
   logic [GW-1:0]    gx_abs, gy_abs;
   logic [MW-1:0]    mag;
   logic [PIX_W-1:0] pix_d;

   // in_sof overrides the counters so a resync always lands on (0,0).
   always_comb begin
      cur_col = in_sof ? '0 : col_q;
      cur_row = in_sof ? '0 : row_q;
      col_d   = cur_col + 1'b1;
      row_d   = cur_row;
      if (cur_col == ColLast) begin
         col_d = '0;
         row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end
      win_ok    = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      first_pix = (cur_row == '0) && (cur_col == '0);
   end

   sobel_stream_filter_line_buffer #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .AW    (CW)
   ) u_line_buffer (
      .clk_i   (sys_clk),
      .we_i    (in_flag),
      .addr_i  (cur_col),
      .wdata_i (data_in),
      .line0_o (lb_line0),
      .line1_o (lb_line1)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         col_q <= '0;
         row_q <= '0;
         thr_q <= PIX_W'(ThrReset);
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (in_flag) begin
         col_q <= col_d;
         row_q <= row_d;
         if (first_pix) begin
            thr_q <= threshold;
         end
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= lb_line1;
         win_q[1][2] <= lb_line0;
         win_q[2][2] <= data_in;
      end
   end

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   always_comb begin
      gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      gy_d = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]))
           - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]));
   end

   always_comb begin
      gx_abs = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
      gy_abs = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
      mag    = {1'b0, gx_abs} + {1'b0, gy_abs};
      if (MODE == ModeBinary) begin
         pix_d = (mag >= MW'(thr1_q)) ? {PIX_W{EdgeBlack}} : {PIX_W{EdgeWhite}};
      end else begin
         pix_d = (mag > MW'(PixMax)) ? PixMax : mag[PIX_W-1:0];
      end
   end

   // The threshold travels with each pixel so a new frame's latch cannot alter
   // outputs of the previous frame still in flight.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v0_q       <= 1'b0;
         sof0_q     <= 1'b0;
         eol0_q     <= 1'b0;
         done0_q    <= 1'b0;
         thr0_q     <= '0;
         gx_q       <= '0;
         gy_q       <= '0;
         v1_q       <= 1'b0;
         sof1_q     <= 1'b0;
         eol1_q     <= 1'b0;
         done1_q    <= 1'b0;
         thr1_q     <= '0;
         data_out   <= '0;
         out_flag   <= 1'b0;
         out_sof    <= 1'b0;
         out_eol    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         v0_q    <= in_flag && win_ok;
         sof0_q  <= in_flag && win_ok && (cur_row == RW'(2)) && (cur_col == CW'(2));
         eol0_q  <= in_flag && win_ok && (cur_col == ColLast);
         done0_q <= in_flag && win_ok && (cur_col == ColLast) && (cur_row == RowLast);
         thr0_q  <= thr_q;

         gx_q    <= gx_d;
         gy_q    <= gy_d;
         v1_q    <= v0_q;
         sof1_q  <= sof0_q;
         eol1_q  <= eol0_q;
         done1_q <= done0_q;
         thr1_q  <= thr0_q;

         out_flag   <= v1_q;
         out_sof    <= sof1_q;
         out_eol    <= eol1_q;
         frame_done <= done1_q;
         if (v1_q) begin
            data_out <= pix_d;
         end
      end
   end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench: binary and magnitude instances driven in parallel on a 5x4 image,
// checking values, markers and 3-clock latency against hand-computed tables.
module tb_sobel_stream_filter;

   localparam int ImgW = 5;
   localparam int ImgH = 4;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] data_in   = '0;
   logic       in_flag   = 1'b0;
   logic       in_sof    = 1'b0;
   logic [7:0] threshold = 8'd12;

   logic [7:0] bin_data, mag_data;
   logic       bin_flag, bin_sof, bin_eol, bin_done;
   logic       mag_flag, mag_sof, mag_eol, mag_done;

   sobel_stream_filter #(
      .PIX_W (8), .IMG_W (ImgW), .IMG_H (ImgH), .MODE (0)
   ) u_dut_bin (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .data_in    (data_in),
      .in_flag    (in_flag),
      .in_sof     (in_sof),
      .threshold  (threshold),
      .data_out   (bin_data),
      .out_flag   (bin_flag),
      .out_sof    (bin_sof),
      .out_eol    (bin_eol),
      .frame_done (bin_done)
   );

   sobel_stream_filter #(
      .PIX_W (8), .IMG_W (ImgW), .IMG_H (ImgH), .MODE (1)
   ) u_dut_mag (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .data_in    (data_in),
      .in_flag    (in_flag),
      .in_sof     (in_sof),
      .threshold  (threshold),
      .data_out   (mag_data),
      .out_flag   (mag_flag),
      .out_sof    (mag_sof),
      .out_eol    (mag_eol),
      .frame_done (mag_done)
   );

   always #5 sys_clk = ~sys_clk;

   logic [31:0] cyc = '0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   typedef struct packed {
      logic [7:0]  d_bin;
      logic [7:0]  d_mag;
      logic        sof;
      logic        eol;
      logic        done;
      logic [31:0] t;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Patterns: 0 flat 100, 1 step 0/255 at col 2, 2 step 0/20 at col 2,
   // 3 vertical step 0/255 at row 2 (negative Gy), 4 ramp 10*(r+c).
   function automatic logic [7:0] pix(input int pat, input int r, input int c);
      case (pat)
         0:       return 8'd100;
         1:       return (c < 2) ? 8'd0 : 8'd255;
         2:       return (c < 2) ? 8'd0 : 8'd20;
         3:       return (r < 2) ? 8'd0 : 8'd255;
         default: return 8'(10 * c + 10 * r);
      endcase
   endfunction

   // Expected values by centre column (both interior rows agree for every pattern).
   function automatic logic [7:0] exp_mag(input int pat, input int cc);
      case (pat)
         0:       return 8'd0;
         1:       return (cc < 3) ? 8'd255 : 8'd0;
         2:       return (cc < 3) ? 8'd80 : 8'd0;
         3:       return 8'd255;
         default: return 8'd160;
      endcase
   endfunction

   function automatic logic [7:0] exp_bin(input int pat, input bit hi_thr, input int cc);
      case (pat)
         0:       return 8'd255;
         1:       return (cc < 3) ? 8'd0 : 8'd255;
         2:       return (hi_thr || cc >= 3) ? 8'd255 : 8'd0;
         3:       return 8'd0;
         default: return hi_thr ? 8'd255 : 8'd0;
      endcase
   endfunction

   always @(negedge sys_clk) begin
      if (sys_rst_n && (bin_flag || mag_flag)) begin
         check("flag_pair", 32'(mag_flag), 32'(bin_flag));
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("bin_data", 32'(bin_data), 32'(mon_e.d_bin));
            check("mag_data", 32'(mag_data), 32'(mon_e.d_mag));
            check("sof", {29'd0, bin_sof, mag_sof, 1'b0}, {29'd0, mon_e.sof, mon_e.sof, 1'b0});
            check("eol", {30'd0, bin_eol, mag_eol}, {30'd0, mon_e.eol, mon_e.eol});
            check("done", {30'd0, bin_done, mag_done}, {30'd0, mon_e.done, mon_e.done});
            check("latency", cyc, mon_e.t);
         end
      end
   end

   task automatic send_pixel(input logic [7:0] d, input logic sof, input logic [7:0] thr,
                             input int gap, output logic [31:0] t);
      @(negedge sys_clk);
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
         in_flag = 1'b0;
         in_sof  = 1'b0;
         @(negedge sys_clk);
      end
      data_in   = d;
      in_sof    = sof;
      threshold = thr;
      in_flag   = 1'b1;
      t         = cyc;
   endtask

   // Threshold input switches from thr_a to thr_b at pixel (1,3); stop >= 0 truncates.
   task automatic send_frame(input int pat, input int gap, input logic [7:0] thr_a,
                             input logic [7:0] thr_b, input bit sof_first, input bit hi_thr,
                             input int stop);
      logic [31:0] t;
      logic [7:0]  thr;
      exp_t        e;
      for (int r = 0; r < ImgH; r++) begin
         for (int c = 0; c < ImgW; c++) begin
            if (stop >= 0 && r * ImgW + c >= stop) return;
            thr = (r > 1 || (r == 1 && c >= 3)) ? thr_b : thr_a;
            send_pixel(pix(pat, r, c), sof_first && r == 0 && c == 0, thr, gap, t);
            if (r >= 2 && c >= 2) begin
               e.d_bin = exp_bin(pat, hi_thr, c - 1);
               e.d_mag = exp_mag(pat, c - 1);
               e.sof   = (r == 2 && c == 2);
               e.eol   = (c == ImgW - 1);
               e.done  = (r == ImgH - 1 && c == ImgW - 1);
               e.t     = t + 3;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic drain(input string tag);
      @(negedge sys_clk);
      in_flag = 1'b0;
      in_sof  = 1'b0;
      repeat (8) @(negedge sys_clk);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_flag", {30'd0, bin_flag, mag_flag}, 32'd0);
      check("rst_data", {16'd0, bin_data, mag_data}, 32'd0);
      check("rst_markers", {26'd0, bin_sof, bin_eol, bin_done, mag_sof, mag_eol, mag_done},
            32'd0);
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      check_reset_outputs();
      sys_rst_n = 1'b1;

      send_frame(0, 0, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      drain("drain_flat");
      send_frame(1, 0, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      drain("drain_step");
      send_frame(1, 30, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      drain("drain_gaps");

      // Threshold change mid-frame applies only from the next frame.
      send_frame(2, 0, 8'd12, 8'd200, 1'b1, 1'b0, -1);
      send_frame(2, 0, 8'd200, 8'd200, 1'b1, 1'b1, -1);
      drain("drain_thr");

      send_frame(3, 0, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      drain("drain_gy_neg");
      send_frame(4, 0, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      send_frame(4, 0, 8'd200, 8'd200, 1'b1, 1'b1, -1);
      drain("drain_ramp");

      // Reset after pixel (2,1); next frame relies on counter reset, not in_sof.
      send_frame(0, 0, 8'd12, 8'd12, 1'b1, 1'b0, 2 * ImgW + 1 + 1);
      @(negedge sys_clk);
      in_flag   = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check_reset_outputs();
      sys_rst_n = 1'b1;
      send_frame(0, 0, 8'd12, 8'd12, 1'b0, 1'b0, -1);
      drain("drain_after_reset");

      // in_sof where pixel (1,2) would have been.
      send_frame(0, 0, 8'd12, 8'd12, 1'b1, 1'b0, ImgW + 2);
      send_frame(0, 0, 8'd12, 8'd12, 1'b1, 1'b0, -1);
      drain("drain_resync");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
